// File: rtl/button_event_classifier_if.sv
// Groups the edge-detector strobes and the classified gesture outputs into one bundle.
// Pure wiring, so it adds no latency.
// No backpressure: every signal is a 1-cycle strobe or a level indicator.
interface button_event_classifier_if;
  // Debounced strobes coming from the button edge detector
  logic i_press_stb;
  logic i_release_stb;
  // Classified gesture strobes and level indicators for the UI logic
  logic o_short_stb;
  logic o_long_stb;
  logic o_double_stb;
  logic o_held;
  logic o_busy;

  // Producer side: drives the strobes and watches the classified events
  modport master (
    output i_press_stb,
    output i_release_stb,
    input  o_short_stb,
    input  o_long_stb,
    input  o_double_stb,
    input  o_held,
    input  o_busy
  );

  // Classifier side
  modport slave (
    input  i_press_stb,
    input  i_release_stb,
    output o_short_stb,
    output o_long_stb,
    output o_double_stb,
    output o_held,
    output o_busy
  );
endinterface

// File: rtl/button_event_classifier.sv
// Classifies press/release strobes into short press, long press or double click.
// Every output is registered; each strobe fires one cycle after its deciding edge.
// No backpressure: strobes are one cycle wide and must be captured by the consumer.
module button_event_classifier #(
  parameter int unsigned LONG_CLKS   = 12500000,
  parameter int unsigned DOUBLE_CLKS = 7500000,
  parameter int unsigned CNT_W       = 24
) (
  input logic                        i_clk,
  input logic                        i_rst,
  button_event_classifier_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    HOLD   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  // Terminal counts: cnt starts at 0 on state entry, so the last cycle of a
  // window of N cycles is the one where cnt == N-1.
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CLKS - 1);
  localparam logic [CNT_W-1:0] DOUBLE_TC = CNT_W'(DOUBLE_CLKS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Both strobes in the same cycle carry no usable information, so they
  // cancel each other and the cycle is treated as idle in every state.
  logic prs_ev;
  logic rel_ev;
  assign prs_ev = bus.i_press_stb & ~bus.i_release_stb;
  assign rel_ev = bus.i_release_stb & ~bus.i_press_stb;

  logic long_tc;
  logic double_tc;
  assign long_tc   = (cnt == LONG_TC);
  assign double_tc = (cnt == DOUBLE_TC);

  logic short_nxt;
  logic long_nxt;
  logic double_nxt;
  logic held_nxt;
  logic busy_nxt;

  // State and window counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state decode; the input event wins over a coinciding terminal count
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (prs_ev) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (rel_ev)       state_nxt = GAP;
        else if (long_tc) state_nxt = HOLD;
      end
      HOLD: begin
        if (rel_ev) state_nxt = IDLE;
      end
      GAP: begin
        if (prs_ev)         state_nxt = PRESS2;
        else if (double_tc) state_nxt = IDLE;
      end
      PRESS2: begin
        // Deliberately no timeout: a held second press is still a double click
        if (rel_ev) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter clears on every state change and only runs in the timed states;
  // the terminal compare always leaves the state before cnt can wrap.
  always_comb begin
    cnt_nxt = '0;
    if (state_nxt == state && (state == PRESS1 || state == GAP)) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // Output decode, computed one cycle ahead so the registered copies line up
  // with the state they describe.
  always_comb begin
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    unique case (state)
      PRESS1:  long_nxt   = ~rel_ev & long_tc;
      GAP:     short_nxt  = ~prs_ev & double_tc;
      PRESS2:  double_nxt = rel_ev;
      default: ;
    endcase
    held_nxt = (state_nxt == HOLD);
    busy_nxt = (state_nxt != IDLE);
  end

  // Registered outputs; reset clears them alongside the state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_short_stb  <= 1'b0;
      bus.o_long_stb   <= 1'b0;
      bus.o_double_stb <= 1'b0;
      bus.o_held       <= 1'b0;
      bus.o_busy       <= 1'b0;
    end else begin
      bus.o_short_stb  <= short_nxt;
      bus.o_long_stb   <= long_nxt;
      bus.o_double_stb <= double_nxt;
      bus.o_held       <= held_nxt;
      bus.o_busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for the gesture classifier with short windows.
// Checks every output on every cycle of each scenario.
// Inputs change just after the rising edge; outputs are sampled on the falling edge.
module tb_button_event_classifier;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  button_event_classifier_if bus ();

  button_event_classifier #(
    .LONG_CLKS   (8),
    .DOUBLE_CLKS (5),
    .CNT_W       (8)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scenario record: event cycles (-1 = none) and expected output cycles.
  // Cycle k output = value visible during cycle k, before its rising edge.
  typedef struct {
    int p1, r1, p2, r2, rst, both, len;
    int s_cyc, l_cyc, d_cyc;
    int held_lo, held_hi, busy_lo, busy_hi;
  } scn_t;

  scn_t scn [9];

  // {short, long, double, held, busy}
  function automatic logic [4:0] outs();
    return {bus.o_short_stb, bus.o_long_stb, bus.o_double_stb, bus.o_held, bus.o_busy};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {s,l,d,held,busy}=%b, expected %b", name, act, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs on the falling edge, advance past the rising edge
  task automatic cyc(input string name, input logic p, input logic r, input logic [4:0] exp);
    bus.i_press_stb   = p;
    bus.i_release_stb = r;
    @(negedge i_clk);
    check(name, outs(), exp);
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_scn(input int idx);
    scn_t s;
    logic [4:0] exp;
    s = scn[idx];
    for (int c = 0; c < s.len; c++) begin
      bus.i_press_stb   = (c == s.p1) || (c == s.p2) || (c == s.both);
      bus.i_release_stb = (c == s.r1) || (c == s.r2) || (c == s.both);
      i_rst             = (c == s.rst);
      exp[4] = (c == s.s_cyc);
      exp[3] = (c == s.l_cyc);
      exp[2] = (c == s.d_cyc);
      exp[1] = (s.held_lo >= 0) && (c >= s.held_lo) && (c <= s.held_hi);
      exp[0] = (s.busy_lo >= 0) && (c >= s.busy_lo) && (c <= s.busy_hi);
      @(negedge i_clk);
      check($sformatf("scn%0d cyc%0d", idx, c), outs(), exp);
      @(posedge i_clk);
      #1;
    end
    // Return to a clean IDLE before the next scenario
    bus.i_press_stb   = 1'b0;
    bus.i_release_stb = 1'b0;
    i_rst             = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    //          p1  r1  p2  r2 rst both len  s   l   d  hlo hhi blo bhi
    scn[0] = '{  0,  3, -1, -1, -1, -1, 14,  9, -1, -1, -1, -1,  1,  8}; // short
    scn[1] = '{  0, 20, -1, -1, -1, -1, 25, -1,  9, -1,  9, 20,  1, 20}; // long
    scn[2] = '{  0,  2,  5, 30, -1, -1, 35, -1, -1, 31, -1, -1,  1, 30}; // double, long 2nd hold
    scn[3] = '{  0,  8, 13, 15, -1, -1, 20, -1, -1, 16, -1, -1,  1, 15}; // both terminal-count races
    scn[4] = '{  0,  6, -1, -1,  4, -1, 12, -1, -1, -1, -1, -1,  1,  4}; // reset mid-press
    scn[5] = '{ -1,  0, -1, -1, -1,  2,  6, -1, -1, -1, -1, -1, -1, -1}; // stray strobes in IDLE
    scn[6] = '{  0,  3, -1, -1, -1,  2, 14,  9, -1, -1, -1, -1,  1,  8}; // both-high in PRESS1
    scn[7] = '{  0,  3, -1, -1, -1,  6, 14,  9, -1, -1, -1, -1,  1,  8}; // both-high in GAP
    scn[8] = '{  0, 20, 12, -1, -1, -1, 25, -1,  9, -1,  9, 20,  1, 20}; // press ignored in HOLD

    bus.i_press_stb   = 1'b0;
    bus.i_release_stb = 1'b0;
    i_rst             = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("reset state", outs(), 5'b00000);
    @(posedge i_clk);
    #1;

    for (int i = 0; i < 9; i++) run_scn(i);

    // Back-to-back: a new press in the same cycle the short strobe appears
    cyc("b2b c0", 1'b1, 1'b0, 5'b00000);
    cyc("b2b c1", 1'b0, 1'b1, 5'b00001);
    for (int c = 2; c <= 6; c++) cyc($sformatf("b2b c%0d", c), 1'b0, 1'b0, 5'b00001);
    cyc("b2b c7", 1'b1, 1'b0, 5'b10000);
    cyc("b2b c8", 1'b0, 1'b0, 5'b00001);
    cyc("b2b c9", 1'b0, 1'b1, 5'b00001);
    for (int c = 10; c <= 14; c++) cyc($sformatf("b2b c%0d", c), 1'b0, 1'b0, 5'b00001);
    cyc("b2b c15", 1'b0, 1'b0, 5'b10000);
    cyc("b2b c16", 1'b0, 1'b0, 5'b00000);

    // Reset while in HOLD: held and busy drop the next cycle, no further strobe
    cyc("hrst c0", 1'b1, 1'b0, 5'b00000);
    for (int c = 1; c <= 8; c++) cyc($sformatf("hrst c%0d", c), 1'b0, 1'b0, 5'b00001);
    cyc("hrst c9", 1'b0, 1'b0, 5'b01011);
    i_rst = 1'b1;
    cyc("hrst c10", 1'b0, 1'b0, 5'b00011);
    i_rst = 1'b0;
    cyc("hrst c11", 1'b0, 1'b1, 5'b00000);
    cyc("hrst c12", 1'b0, 1'b0, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_classifier.md
Name: button_event_classifier

Overview:
- Consumes the debounced 1-cycle press/release strobes produced by the button edge detector.
- Classifies each user gesture into exactly one of three events: short press, long press, or double click.
- Emits one registered 1-cycle strobe per gesture, plus level indicators for UI logic.
- Sits between the edge detector and the CPU-visible button/GPIO event register.

Parameters:
- LONG_CLKS, 12500000, cycles a press must be held to count as long (500 ms at 25 MHz); must be >= 2.
- DOUBLE_CLKS, 7500000, cycles after a short release during which a second press makes a double click (300 ms at 25 MHz); must be >= 2.
- CNT_W, 24, counter width; must satisfy 2^CNT_W > max(LONG_CLKS, DOUBLE_CLKS).

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous active-high reset
- i_press_stb  input  1  1-cycle strobe, debounced button press
- i_release_stb  input  1  1-cycle strobe, debounced button release
- o_short_stb  output  1  1-cycle strobe, single short press completed
- o_long_stb  output  1  1-cycle strobe, hold threshold reached
- o_double_stb  output  1  1-cycle strobe, double click completed
- o_held  output  1  level, high while a long press is still held
- o_busy  output  1  level, high whenever state != IDLE

Behaviour:
Reset:
- i_rst sampled on posedge i_clk, synchronous.
- Forces state = IDLE and cnt = 0.
- All outputs read 0 in the cycle after reset is sampled.
- Reset mid-gesture discards the gesture; no strobe is emitted for it.

Outputs and counter:
- All outputs are registered.
- The three strobes are mutually exclusive and never high for more than 1 consecutive cycle.
- cnt is CNT_W bits wide, cleared on every state entry, and increments by 1 each cycle in PRESS1 and GAP.
- cnt cannot wrap, because the terminal compare always fires first.

Input sanitising:
- i_press_stb and i_release_stb high in the same cycle: treated as no event in every state.
- Any strobe not listed for the current state below is ignored.

States:
- IDLE: press -> PRESS1.
- PRESS1:
  - release -> GAP.
  - else if cnt == LONG_CLKS-1 -> HOLD, o_long_stb = 1 next cycle.
  - A release in the terminal-count cycle wins: go to GAP, no long strobe.
- HOLD:
  - o_held = 1 for every cycle in HOLD.
  - release -> IDLE; no further strobe.
- GAP:
  - press -> PRESS2.
  - else if cnt == DOUBLE_CLKS-1 -> IDLE, o_short_stb = 1 next cycle.
  - A press in the terminal-count cycle wins: go to PRESS2, no short strobe.
- PRESS2:
  - release -> IDLE, o_double_stb = 1 next cycle.
  - No timeout: a long hold on the second press still yields a double click on release.

Latency (press strobe at cycle t):
- State = PRESS1 at t+1 with cnt = 0.
- Long: o_long_stb at t+LONG_CLKS+1; o_held high from that cycle until the cycle after the release.
- Short: release at cycle r gives GAP at r+1; o_short_stb at r+DOUBLE_CLKS+1 if no press arrives in r+1 .. r+DOUBLE_CLKS.
- Double: o_double_stb in the cycle after the second release.
- o_busy goes high the cycle after the first press and low in the same cycle the final strobe asserts (or the cycle after the release from HOLD).

Test Plan:
(Bench uses LONG_CLKS=8, DOUBLE_CLKS=5; cycle 0 = first press strobe.)
- Press at 0, release at 3 -> o_short_stb high only at cycle 9; o_long_stb and o_double_stb stay 0; o_busy high cycles 1..8.
- Press at 0, no release -> o_long_stb high only at cycle 9; o_held high from 9. Then release at 20 -> o_held low at 21; no other strobe.
- Press at 0, release at 2, press at 5, release at 30 -> o_double_stb high only at cycle 31; no short or long strobe.
- Release at cycle 8 (terminal count) after press at 0 -> no o_long_stb. Second press at 13 (GAP terminal cycle) -> PRESS2, no o_short_stb at 14; release at 15 -> o_double_stb at 16.
- Press at 0, i_rst high at 4, release at 6 -> all outputs 0 from cycle 5 onward; no strobe ever emitted.
- Release alone in IDLE, and press+release in the same cycle in IDLE and in PRESS1 -> no state change, all outputs 0, timing of any gesture in progress unchanged.
